mem_model_q: RTL and testbench

- Clocked, parametrised successor to the unclocked line-fill memory model used by the I-cache refill path.
- Accepts line-read requests through a valid/ready handshake and buffers them in an in-order request queue.
- Returns one full cache line per request after a fixed, configurable latency.
- Line data is a deterministic function of address and seed, so the cache bench can self-check fills without a backing array.
- Supports optional out-of-range error responses.

---
 rtl/mem_model_q.sv | 204 ++++++++++++++++++++
 tb/tb_mem_model_q.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_model_q.sv
// ---------------------------------------------------------------------------
// mem_model_q
//
// Clocked line-fill memory model for the I-cache refill path. Line-read
// requests are accepted through a valid/ready handshake into an in-order
// queue. Each request is answered with one full cache line after a fixed
// latency. Line data is derived from the address and SEED, so a cache bench
// can self-check fills without a backing array. If ADDR_LIMIT is non-zero,
// addresses at or above it return an error response with zero data.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            synchronous reset, active-high
//   mem_req        request valid
//   mem_addr       byte address of the request
//   mem_req_ready  queue can accept this cycle (from registered count only)
//   mem_ready      single-cycle response valid pulse
//   mem_data       returned line, word 0 in the LSBs
//   mem_resp_addr  line-aligned address of the response
//   mem_err        out-of-range error, qualified by mem_ready
//   mem_busy       queue non-empty or service in progress
// ---------------------------------------------------------------------------
module mem_model_q #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned LATENCY    = 4,
    parameter logic [31:0] SEED       = 32'h0000_0000,
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req_ready,
    output logic                  mem_ready,
    output logic [LINE_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_resp_addr,
    output logic                  mem_err,
    output logic                  mem_busy
);

    localparam int unsigned OFF_BITS = $clog2(LINE_WIDTH / 8);
    localparam int unsigned WORDS    = LINE_WIDTH / 32;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned LAT_W    = $clog2(LATENCY + 1);

    localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [LAT_W-1:0]      LAT_FULL   = LAT_W'(LATENCY);
    localparam logic [LAT_W-1:0]      LAT_FIRST  = LAT_W'(LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFF_BITS;
    localparam logic [ADDR_WIDTH-1:0] LIMIT_A    = ADDR_WIDTH'(ADDR_LIMIT);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    // Service state
    state_t                 state_q, state_d;
    logic [LAT_W-1:0]       lat_q, lat_d;

    // Request queue
    logic [ADDR_WIDTH-1:0]  fifo_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    // Registered response
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;
    logic [LINE_WIDTH-1:0]  data_q, data_d;
    logic [ADDR_WIDTH-1:0]  resp_addr_q, resp_addr_d;
    logic                   busy_q, busy_d;

    logic                   accept;
    logic                   pop;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [31:0]            line_base;
    logic [LINE_WIDTH-1:0]  line_word;
    logic                   head_oor;

    assign head_addr = fifo_q[rd_ptr_q];

    // Readiness comes from the registered count alone, so a pop at the
    // coming edge never lets a request slip into a queue that starts full.
    assign mem_req_ready = (count_q < DEPTH_C);
    assign accept        = mem_req && mem_req_ready;

    // Line pattern for the head entry: word i = (A + 4i) ^ SEED, 32-bit wrap.
    always_comb begin
        line_base = 32'(head_addr);
        line_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            line_word[i*32 +: 32] = (line_base + 32'(4 * i)) ^ SEED;
        end
    end

    assign head_oor = (ADDR_LIMIT != 32'd0) && (head_addr >= LIMIT_A);

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ready_d     = 1'b0;
        err_d       = 1'b0;
        data_d      = data_q;
        resp_addr_d = resp_addr_q;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                // One edge is spent leaving IDLE, hence LATENCY-1 here.
                if (count_q != '0) begin
                    state_d = S_WAIT;
                    lat_d   = LAT_FIRST;
                end
            end
            S_WAIT: begin
                if (lat_q == LAT_W'(1)) begin
                    pop         = 1'b1;
                    ready_d     = 1'b1;
                    resp_addr_d = head_addr;
                    err_d       = head_oor;
                    data_d      = head_oor ? '0 : line_word;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            fifo_d[wr_ptr_q] = mem_addr & ALIGN_MASK;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Chain straight into the next entry so back-to-back responses are
        // exactly LATENCY apart; an accept on the pop edge counts as "more".
        if (pop) begin
            if (count_d != '0) begin
                state_d = S_WAIT;
                lat_d   = LAT_FULL;
            end else begin
                state_d = S_IDLE;
            end
        end

        busy_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= '0;
            resp_addr_q <= '0;
            busy_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            data_q      <= data_d;
            resp_addr_q <= resp_addr_d;
            busy_q      <= busy_d;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    assign mem_ready     = ready_q;
    assign mem_err       = err_q;
    assign mem_data      = data_q;
    assign mem_resp_addr = resp_addr_q;
    assign mem_busy      = busy_q;

endmodule

// File: tb/tb_mem_model_q.sv
// ---------------------------------------------------------------------------
// tb_mem_model_q
//
// Three instances share clock and reset: u0 with defaults, u1 with
// ADDR_LIMIT=0x0001_0000, u2 with SEED=0xA5A5_A5A5. Directed scenarios check
// reset, latency, queue-full/wrap, errors, seed/address wrap and mid-run
// reset; a randomized run compares against a timing/data model built from
// the latency contract (response edge = max(accept+L, previous response+L)).
// ---------------------------------------------------------------------------
module tb_mem_model_q;

    localparam int L = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req   [3];
    logic [31:0]  addr  [3];
    logic         rdy   [3];
    logic         vld   [3];
    logic [127:0] data  [3];
    logic [31:0]  raddr [3];
    logic         err   [3];
    logic         busy  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_model_q u0 (
        .clk(clk), .rst(rst), .mem_req(req[0]), .mem_addr(addr[0]),
        .mem_req_ready(rdy[0]), .mem_ready(vld[0]), .mem_data(data[0]),
        .mem_resp_addr(raddr[0]), .mem_err(err[0]), .mem_busy(busy[0])
    );

    mem_model_q #(.ADDR_LIMIT(32'h0001_0000)) u1 (
        .clk(clk), .rst(rst), .mem_req(req[1]), .mem_addr(addr[1]),
        .mem_req_ready(rdy[1]), .mem_ready(vld[1]), .mem_data(data[1]),
        .mem_resp_addr(raddr[1]), .mem_err(err[1]), .mem_busy(busy[1])
    );

    mem_model_q #(.SEED(32'hA5A5_A5A5)) u2 (
        .clk(clk), .rst(rst), .mem_req(req[2]), .mem_addr(addr[2]),
        .mem_req_ready(rdy[2]), .mem_ready(vld[2]), .mem_data(data[2]),
        .mem_resp_addr(raddr[2]), .mem_err(err[2]), .mem_busy(busy[2])
    );

    // ---------------- reference model helpers ----------------
    function automatic logic [31:0] seed_of(input int inst);
        return (inst == 2) ? 32'hA5A5_A5A5 : 32'h0;
    endfunction

    function automatic logic [31:0] limit_of(input int inst);
        return (inst == 1) ? 32'h0001_0000 : 32'h0;
    endfunction

    function automatic bit ref_err(input int inst, input logic [31:0] a);
        return (limit_of(inst) != 0) && (a >= limit_of(inst));
    endfunction

    function automatic logic [127:0] ref_line(input int inst, input logic [31:0] a);
        logic [127:0] r;
        r = '0;
        if (!ref_err(inst, a)) begin
            for (int i = 0; i < 4; i++) r[32*i +: 32] = (a + 32'(4 * i)) ^ seed_of(inst);
        end
        return r;
    endfunction

    typedef struct {
        logic [31:0] a;
        int          t;
    } pend_t;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i]  = 1'b1;
            addr[i] = 32'h40;
        end
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (vld[i] !== 1'b0 || err[i] !== 1'b0 || busy[i] !== 1'b0 ||
                    data[i] !== '0 || raddr[i] !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs inst%0d: vld=%b err=%b busy=%b data=%h raddr=%h, required all 0",
                             i, vld[i], err[i], busy[i], data[i], raddr[i]);
                end
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rdy[i] !== 1'b1 || busy[i] !== 1'b0 || vld[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release inst%0d: rdy=%b busy=%b vld=%b, required rdy=1 busy=0 vld=0",
                         i, rdy[i], busy[i], vld[i]);
            end
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        checks++;
        if (rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_req_ready: got %b, required 1", rdy[0]);
        end
        req[0]  = 1'b1;
        addr[0] = 32'h0000_1234;
        @(negedge clk);                       // after accept edge t
        req[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: got %b, required 1", busy[0]);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);                   // after edge t+k
            checks++;
            if (vld[0] !== (k == L)) begin
                errors++;
                $display("FAIL single_ready_timing edge t+%0d: got %b, required %b", k, vld[0], (k == L));
            end
            if (k == L) begin
                checks++;
                if (raddr[0] !== 32'h0000_1230 || err[0] !== 1'b0 ||
                    data[0] !== 128'h0000123C_00001238_00001234_00001230) begin
                    errors++;
                    $display("FAIL single_resp: addr=%h err=%b data=%h, required addr=00001230 err=0 data=0000123c000012380000123400001230",
                             raddr[0], err[0], data[0]);
                end
            end
            if (k == L + 1) begin
                checks++;
                if (busy[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL single_busy_after: got %b, required 0", busy[0]);
                end
            end
        end
    endtask

    task automatic test_full_wrap();
        int  idx;
        int  nr;
        bit  ev;
        int  pe;
        idx = 0;
        nr  = 0;
        for (int e = 0; e <= 22; e++) begin
            @(negedge clk);                   // state after edge e-1
            if (e > 0) begin
                pe = e - 1;
                ev = (pe >= 4) && (pe <= 20) && (pe % 4 == 0);
                checks++;
                if (vld[0] !== ev) begin
                    errors++;
                    $display("FAIL wrap_resp_timing edge %0d: got %b, required %b", pe, vld[0], ev);
                end
                if (ev && vld[0] === 1'b1) begin
                    checks++;
                    if (raddr[0] !== 32'(32'h100 * (nr + 1))) begin
                        errors++;
                        $display("FAIL wrap_resp_order resp %0d: got %h, required %h", nr, raddr[0], 32'h100 * (nr + 1));
                    end
                    nr++;
                end
            end
            if (idx < 5) begin
                checks++;
                if (rdy[0] !== (e != 4)) begin
                    errors++;
                    $display("FAIL wrap_req_ready before edge %0d: got %b, required %b", e, rdy[0], (e != 4));
                end
                req[0]  = 1'b1;
                addr[0] = 32'(32'h100 * (idx + 1));
                if (rdy[0] === 1'b1) idx++;
            end else begin
                req[0] = 1'b0;
            end
        end
        req[0] = 1'b0;
        checks++;
        if (nr != 5) begin
            errors++;
            $display("FAIL wrap_resp_count: got %0d, required 5", nr);
        end
    endtask

    task automatic test_range();
        logic [31:0]  ra [2];
        logic [127:0] rd [2];
        bit           re [2];
        int           nr;
        bit           ev;
        ra[0] = 32'h0002_0000;  rd[0] = '0;                                      re[0] = 1'b1;
        ra[1] = 32'h0000_0040;  rd[1] = 128'h0000004C_00000048_00000044_00000040; re[1] = 1'b0;
        nr = 0;
        for (int e = 0; e <= 10; e++) begin
            @(negedge clk);
            if (e > 0) begin
                ev = (e - 1 == 4) || (e - 1 == 8);
                checks++;
                if (vld[1] !== ev) begin
                    errors++;
                    $display("FAIL range_resp_timing edge %0d: got %b, required %b", e - 1, vld[1], ev);
                end
                if (ev && nr < 2) begin
                    checks++;
                    if (raddr[1] !== ra[nr] || err[1] !== re[nr] || data[1] !== rd[nr]) begin
                        errors++;
                        $display("FAIL range_resp %0d: addr=%h err=%b data=%h, required addr=%h err=%b data=%h",
                                 nr, raddr[1], err[1], data[1], ra[nr], re[nr], rd[nr]);
                    end
                    nr++;
                end else begin
                    checks++;
                    if (err[1] !== 1'b0) begin
                        errors++;
                        $display("FAIL range_err_idle edge %0d: got %b, required 0", e - 1, err[1]);
                    end
                end
            end
            req[1]  = (e < 2);
            addr[1] = (e == 0) ? 32'h0002_0000 : 32'h0000_0040;
        end
        req[1] = 1'b0;
    endtask

    task automatic test_seed_wrap();
        @(negedge clk);
        req[2]  = 1'b1;
        addr[2] = 32'hFFFF_FFF4;
        @(negedge clk);
        req[2] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (vld[2] !== (k == L)) begin
                errors++;
                $display("FAIL seed_ready_timing edge t+%0d: got %b, required %b", k, vld[2], (k == L));
            end
            if (k == L) begin
                checks++;
                if (raddr[2] !== 32'hFFFF_FFF0 || err[2] !== 1'b0 ||
                    data[2] !== 128'h5A5A5A59_5A5A5A5D_5A5A5A51_5A5A5A55) begin
                    errors++;
                    $display("FAIL seed_wrap_resp: addr=%h err=%b data=%h, required addr=fffffff0 err=0 data=5a5a5a595a5a5a5d5a5a5a515a5a5a55",
                             raddr[2], err[2], data[2]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req[0] = 1'b1;  addr[0] = 32'h300;    // accepted at edge 0
        @(negedge clk);
        addr[0] = 32'h340;                    // accepted at edge 1
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before: got %b, required 1", busy[0]);
        end
        addr[0] = 32'h380;
        rst     = 1'b1;                       // reset at edge 2
        @(negedge clk);
        rst    = 1'b0;
        req[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (vld[0] !== 1'b0 || busy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
                errors++;
                $display("FAIL midrst_quiet cycle %0d: vld=%b busy=%b rdy=%b, required vld=0 busy=0 rdy=1",
                         k, vld[0], busy[0], rdy[0]);
            end
            @(negedge clk);
        end
        req[0]  = 1'b1;
        addr[0] = 32'h84;
        @(negedge clk);
        req[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (vld[0] !== (k == L)) begin
                errors++;
                $display("FAIL midrst_after_timing edge t+%0d: got %b, required %b", k, vld[0], (k == L));
            end
            if (k == L) begin
                checks++;
                if (raddr[0] !== 32'h80 || data[0] !== ref_line(0, 32'h80)) begin
                    errors++;
                    $display("FAIL midrst_after_resp: addr=%h data=%h, required addr=00000080 data=%h",
                             raddr[0], data[0], ref_line(0, 32'h80));
                end
            end
        end
    endtask

    task automatic test_random(input int inst, input int ncyc);
        pend_t        q[$];
        pend_t        p;
        int           last_t;
        logic [31:0]  la;
        logic [127:0] ld;
        bit           le;
        bit           ev;
        logic [31:0]  a;
        last_t = -100;
        la = '0;
        ld = '0;
        le = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < ncyc + 40; n++) begin
            // state after edge n-1
            ev = 1'b0;
            if (q.size() > 0 && q[0].t == n - 1) begin
                ev = 1'b1;
                la = q[0].a;
                ld = ref_line(inst, la);
                le = ref_err(inst, la);
                void'(q.pop_front());
            end
            checks++;
            if (vld[inst] !== ev) begin
                errors++;
                $display("FAIL rand%0d_ready edge %0d: got %b, required %b", inst, n - 1, vld[inst], ev);
            end
            checks++;
            if (raddr[inst] !== la || data[inst] !== ld) begin
                errors++;
                $display("FAIL rand%0d_resp edge %0d: addr=%h data=%h, required addr=%h data=%h",
                         inst, n - 1, raddr[inst], data[inst], la, ld);
            end
            checks++;
            if (err[inst] !== (ev && le)) begin
                errors++;
                $display("FAIL rand%0d_err edge %0d: got %b, required %b", inst, n - 1, err[inst], (ev && le));
            end
            checks++;
            if (rdy[inst] !== (q.size() < D) || busy[inst] !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rand%0d_flow edge %0d: rdy=%b busy=%b, required rdy=%b busy=%b",
                         inst, n - 1, rdy[inst], busy[inst], (q.size() < D), (q.size() != 0));
            end
            if (n < ncyc && $urandom_range(0, 9) < 6) begin
                a = (inst == 1) ? 32'($urandom_range(0, 32'h1_FFFF)) : 32'($urandom);
                req[inst]  = 1'b1;
                addr[inst] = a;
                if (q.size() < D) begin
                    p.a = a & ~32'hF;
                    p.t = (n + L > last_t + L) ? n + L : last_t + L;
                    last_t = p.t;
                    q.push_back(p);
                end
            end else begin
                req[inst] = 1'b0;
            end
            @(negedge clk);
        end
        req[inst] = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rand%0d_drain: %0d responses outstanding, required 0", inst, q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req[i]  = 1'b0;
            addr[i] = '0;
        end
        test_reset();
        test_single();
        test_full_wrap();
        test_range();
        test_seed_wrap();
        test_reset_mid();
        test_random(0, 400);
        test_random(1, 400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
